grn_out_scheduler: RTL and testbench



---
 rtl/grn_sched_pkg.sv | 14 +
 rtl/grn_out_scheduler_if.sv | 28 ++
 rtl/grn_rr_pick.sv | 27 ++
 rtl/grn_out_scheduler.sv | 85 ++++++++
 tb/tb_grn_out_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grn_sched_pkg.sv
// Shared constants and types for the GRN output scheduler.
// Latency: none (definitions only). Backpressure: not applicable.
// Holds requester count, select width and the FSM state codes.
package grn_sched_pkg;
    localparam int NREQ  = 32;
    localparam int SEL_W = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    typedef logic [NREQ-1:0]  req_t;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/grn_out_scheduler_if.sv
// Core-array / mux / downstream signals of the output scheduler.
// Latency: none (wiring only). Backpressure: out_ready from the slave side.
// master = scheduler, slave = core array, mux and result writer.
interface grn_out_scheduler_if #(
    parameter int WIDTH = 256
);
    import grn_sched_pkg::*;

    req_t             req;
    req_t             grant;
    sel_t             sel;
    logic [WIDTH-1:0] mux_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    sel_t             out_src;
    logic             busy;

    modport master (
        input  req, mux_out, out_ready,
        output grant, sel, out_valid, out_data, out_src, busy
    );

    modport slave (
        output req, mux_out, out_ready,
        input  grant, sel, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/grn_rr_pick.sv
// Rotating priority encoder: first set req bit scanning from ptr upward with wrap.
// Latency: combinational. Backpressure: none.
// any=0 means no request; idx is then 0.
module grn_rr_pick
    import grn_sched_pkg::*;
(
    input  req_t req,
    input  sel_t ptr,
    output logic any,
    output sel_t idx
);
    sel_t cand;

    // Scan from the far end so the candidate nearest ptr is written last and wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/grn_out_scheduler.sv
// Round-robin share of one 32:1 result mux; captures the selected word and forwards it.
// Latency: req in IDLE -> grant next cycle -> out_valid the cycle after; one word per 2 cycles.
// Backpressure: out_ready low holds OUT with word, source and sel frozen; no grants meanwhile.
module grn_out_scheduler
    import grn_sched_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    grn_out_scheduler_if.master bus
);
    logic [1:0]       state_q, state_d;
    sel_t             ptr_q, sel_q, src_q;
    logic [WIDTH-1:0] data_q;
    sel_t             pick_ptr, pick_idx;
    logic             pick_any;
    logic             req_sel, hs;
    req_t             grant;
    logic             out_valid, busy;

    assign req_sel = bus.req[sel_q];
    assign hs      = (state_q == OUT) && bus.out_ready;
    // On a handshake the pointer update must already be visible to this cycle's pick.
    assign pick_ptr = (state_q == OUT) ? src_q + SEL_W'(1) : ptr_q;

    grn_rr_pick u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = LOAD;
            LOAD:    state_d = req_sel ? OUT : IDLE;
            OUT:     if (bus.out_ready) state_d = pick_any ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        if (state_q == LOAD && req_sel) grant[sel_q] = 1'b1;
    end

    // A withdrawn request in LOAD leaves ptr, data and source untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            sel_q  <= '0;
            src_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (pick_any) sel_q <= pick_idx;
                LOAD: if (req_sel) begin
                    data_q <= bus.mux_out;
                    src_q  <= sel_q;
                end
                OUT: if (hs) begin
                    ptr_q <= pick_ptr;
                    if (pick_any) sel_q <= pick_idx;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_grn_out_scheduler.sv
// Directed and randomized bench for grn_out_scheduler with a queue-based reference model.
module tb_grn_out_scheduler;
    localparam int W = 256;

    typedef struct {
        logic [4:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] words [32][4];
    logic [2:0]   cnt [32];
    logic [2:0]   hd [32];
    exp_t         expq [$];

    grn_out_scheduler_if #(.WIDTH(W)) bus ();

    grn_out_scheduler #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Mux model: input i carries the head word of core i's queue.
    always_comb bus.mux_out = words[bus.sel][hd[bus.sel][1:0]];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    task automatic clear();
        for (int i = 0; i < 32; i++) begin
            cnt[i] = '0;
            hd[i]  = '0;
            for (int k = 0; k < 4; k++) words[i][k] = rnd_word();
        end
        expq.delete();
    endtask

    task automatic push_exp(input int core, input int nth);
        exp_t e;
        e.src  = 5'(core);
        e.data = words[core][nth];
        expq.push_back(e);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n = 1'b0;
        edge_();
        edge_();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   W'(bus.sel),       '0);
        chk({tag, "_grant"}, W'(bus.grant),     '0);
        chk({tag, "_valid"}, W'(bus.out_valid), '0);
        chk({tag, "_data"},  bus.out_data,      '0);
        chk({tag, "_src"},   W'(bus.out_src),   '0);
        chk({tag, "_busy"},  W'(bus.busy),      '0);
    endtask

    // Cores request while their queue is non-empty; each grant pops the head word.
    task automatic run_auto(input bit rnd_ready, input bit rate, input int budget);
        int          cyc = 0;
        int          last = -1;
        logic [31:0] g;
        exp_t        e;
        while (expq.size() > 0 && cyc < budget) begin
            for (int i = 0; i < 32; i++) bus.req[i] = (cnt[i] > hd[i]);
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            mid();
            chk("grant_onehot", W'($onehot0(bus.grant)), W'(1));
            if (bus.grant != '0) chk("grant_sel", W'(bus.grant), W'(32'b1 << bus.sel));
            if (bus.out_valid && bus.out_ready) begin
                e = expq.pop_front();
                chk("out_src", W'(bus.out_src), W'(e.src));
                chk("out_data", bus.out_data, e.data);
                if (rate && last >= 0) chk("word_gap", W'(cyc - last), W'(2));
                last = cyc;
            end
            g = bus.grant;
            edge_();
            for (int i = 0; i < 32; i++) if (g[i]) hd[i] = hd[i] + 3'd1;
            cyc++;
        end
        chk("drain_remaining", W'(expq.size()), '0);
        bus.req = '0;
        bus.out_ready = 1'b1;
        edge_();
        edge_();
    endtask

    // Reference order: from pointer p, serve the first core with words left, then p = core+1.
    task automatic build_model();
        int rem [32];
        int nxt [32];
        int total = 0;
        int p = 0;
        int j;
        for (int i = 0; i < 32; i++) begin
            rem[i] = int'(cnt[i]);
            nxt[i] = 0;
            total += rem[i];
        end
        while (total > 0) begin
            j = p;
            for (int k = 0; k < 32; k++) begin
                j = (p + k) % 32;
                if (rem[j] > 0) break;
            end
            push_exp(j, nxt[j]);
            nxt[j]++;
            rem[j]--;
            total--;
            p = (j + 1) % 32;
        end
    endtask

    initial begin
        logic [W-1:0] w;
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a5;
        bus.req = '0;
        bus.out_ready = 1'b1;
        clear();
        a5 = {8{32'hA5A5_A5A5}};

        // Reset state
        edge_();
        mid();
        chk_reset_vals("reset");
        edge_();
        rst_n = 1'b1;
        edge_();

        // Single requester: core 2
        words[2][0] = a5;
        bus.req = 32'h0000_0004;
        mid();
        chk("single_t_busy", W'(bus.busy), '0);
        edge_();
        mid();
        chk("single_sel", W'(bus.sel), W'(2));
        chk("single_grant", W'(bus.grant), W'(32'h4));
        chk("single_t1_valid", W'(bus.out_valid), '0);
        edge_();
        bus.req = '0;
        mid();
        chk("single_valid", W'(bus.out_valid), W'(1));
        chk("single_data", bus.out_data, a5);
        chk("single_src", W'(bus.out_src), W'(2));
        chk("single_no_grant", W'(bus.grant), '0);
        edge_();
        mid();
        chk("single_after_valid", W'(bus.out_valid), '0);
        chk("single_after_busy", W'(bus.busy), '0);
        edge_();

        // Withdrawn request: core 4 drops in LOAD; pointer must stay at 3
        bus.req = 32'h0000_0010;
        mid();
        edge_();
        bus.req = '0;
        mid();
        chk("wd_load_busy", W'(bus.busy), W'(1));
        chk("wd_no_grant", W'(bus.grant), '0);
        edge_();
        mid();
        chk("wd_idle_busy", W'(bus.busy), '0);
        chk("wd_no_valid", W'(bus.out_valid), '0);
        edge_();
        clear();
        cnt[2] = 3'd1;
        cnt[4] = 3'd1;
        push_exp(4, 0);
        push_exp(2, 0);
        run_auto(1'b0, 1'b0, 100);

        // Wrap-around: serve 30, then 31 before 0
        clear();
        cnt[30] = 3'd1;
        push_exp(30, 0);
        run_auto(1'b0, 1'b0, 100);
        clear();
        cnt[31] = 3'd1;
        cnt[0] = 3'd1;
        push_exp(31, 0);
        push_exp(0, 0);
        run_auto(1'b0, 1'b1, 100);

        // Backpressure: core 7 held 10 cycles, core 8 waits without a grant
        clear();
        bus.out_ready = 1'b0;
        bus.req = 32'h0000_0080;
        mid();
        edge_();
        mid();
        chk("bp_grant7", W'(bus.grant), W'(32'h80));
        edge_();
        bus.req = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("bp_valid", W'(bus.out_valid), W'(1));
            chk("bp_data", bus.out_data, words[7][0]);
            chk("bp_src", W'(bus.out_src), W'(7));
            chk("bp_no_grant", W'(bus.grant), '0);
            edge_();
        end
        bus.out_ready = 1'b1;
        mid();
        chk("bp_release_valid", W'(bus.out_valid), W'(1));
        edge_();
        mid();
        chk("bp_next_grant8", W'(bus.grant), W'(32'h100));
        chk("bp_hs_done", W'(bus.out_valid), '0);
        edge_();
        bus.req = '0;
        mid();
        chk("bp_src8", W'(bus.out_src), W'(8));
        chk("bp_data8", bus.out_data, words[8][0]);
        edge_();
        mid();
        chk("bp_idle", W'(bus.busy), '0);
        edge_();

        // Reset while a word is held in OUT
        clear();
        bus.out_ready = 1'b0;
        bus.req = 32'h0000_0040;
        mid();
        edge_();
        edge_();
        bus.req = '0;
        mid();
        chk("rst_pre_valid", W'(bus.out_valid), W'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        edge_();
        edge_();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear();
        cnt[3] = 3'd1;
        push_exp(3, 0);
        run_auto(1'b0, 1'b0, 100);

        // All cores requesting, two words each, from pointer 0
        do_reset();
        clear();
        for (int i = 0; i < 32; i++) cnt[i] = 3'd2;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 32; i++) push_exp(i, r);
        run_auto(1'b0, 1'b1, 500);

        // Randomized load with random backpressure against the reference order
        do_reset();
        clear();
        for (int i = 0; i < 32; i++) cnt[i] = 3'($urandom_range(0, 4));
        build_model();
        run_auto(1'b1, 1'b0, 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
